// File: rtl/mic_spi_rx_multi_pkg.sv
// mic_spi_pkg: shared types and helpers for the multi-channel
// SPI microphone receiver and its benches.
package mic_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    // clk cycles from one cs fall to the next in continuous framing
    function automatic int frame_period(
        input int div_log2,
        input int frame_bits,
        input int gap_cycles
    );
        return (1 << div_log2)
             + 2 * (1 << div_log2) * frame_bits
             + gap_cycles;
    endfunction

    localparam int FRAME_PERIOD_DEF = frame_period(3, 32, 64);

    // unsigned magnitude; the most negative value maps to 2^31
    function automatic logic [31:0] abs_mag(
        input logic signed [31:0] x
    );
        return x[31] ? -x : x;
    endfunction

endpackage

// File: rtl/mic_spi_rx_multi_if.sv
// mic_spi_rx_multi_if: sample delivery handshake between the
// receiver (master) and the audio pipeline (slave).
interface mic_spi_rx_multi_if #(
    parameter int N_CH     = 1,
    parameter int SAMPLE_W = 16
);
    logic [N_CH*SAMPLE_W-1:0] sample;
    logic                     valid;
    logic                     ready;
    logic                     overrun;

    modport master (
        output sample,
        output valid,
        output overrun,
        input  ready
    );

    modport slave (
        input  sample,
        input  valid,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/mic_spi_rx_multi_sck_gen.sv
// mic_spi_sck_gen: frame FSM producing cs/sck plus the per-bit
// capture strobe and the end-of-frame strobe.
module mic_spi_sck_gen
    import mic_spi_pkg::*;
#(
    parameter int DIV_LOG2   = 3,
    parameter int FRAME_BITS = 32,
    parameter int GAP_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic cs,
    output logic sck,
    output logic capture,
    output logic frame_done
);

    localparam int H  = 1 << DIV_LOG2;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int PW = (DIV_LOG2 > GW) ? DIV_LOG2 : GW;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [PW-1:0] PH_HALF  = PW'(H - 1);
    localparam logic [PW-1:0] PH_GAP   = PW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic          cs_n, sck_n;

    // state, counters and the registered cs/sck pins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            cs      <= 1'b1;
            sck     <= 1'b1;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            cs      <= cs_n;
            sck     <= sck_n;
        end
    end

    // next state, counter reloads and strobes; sck low half ends
    // with a capture, first cycle of the last high half ends the frame
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        bit_n      = bit_cnt;
        cs_n       = cs;
        sck_n      = sck;
        capture    = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            IDLE: begin
                cs_n  = 1'b1;
                sck_n = 1'b1;
                if (enable) begin
                    state_n = SETUP;
                    cs_n    = 1'b0;
                    phase_n = PH_HALF;
                end
            end
            SETUP: begin
                if (phase == '0) begin
                    state_n = SHIFT;
                    sck_n   = 1'b0;
                    phase_n = PH_HALF;
                    bit_n   = BIT_LAST;
                end else begin
                    phase_n = phase - PH_ONE;
                end
            end
            SHIFT: begin
                if (!sck) begin
                    if (phase == '0) begin
                        capture = 1'b1;
                        sck_n   = 1'b1;
                        phase_n = PH_HALF;
                    end else begin
                        phase_n = phase - PH_ONE;
                    end
                end else begin
                    frame_done = (bit_cnt == '0) && (phase == PH_HALF);
                    if (phase == '0) begin
                        if (bit_cnt == '0) begin
                            state_n = GAP;
                            cs_n    = 1'b1;
                            phase_n = PH_GAP;
                        end else begin
                            bit_n   = bit_cnt - BIT_ONE;
                            sck_n   = 1'b0;
                            phase_n = PH_HALF;
                        end
                    end else begin
                        phase_n = phase - PH_ONE;
                    end
                end
            end
            GAP: begin
                if (phase == '0) begin
                    if (enable) begin
                        state_n = SETUP;
                        cs_n    = 1'b0;
                        phase_n = PH_HALF;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    phase_n = phase - PH_ONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mic_spi_rx_multi.sv
// mic_spi_rx_multi: N_CH-channel SPI mic/ADC receiver, one
// shared cs/sck. Peak tracker built only with MIC_SPI_PEAK_EN.
module mic_spi_rx_multi
    import mic_spi_pkg::*;
#(
    parameter int N_CH       = 1,
    parameter int DIV_LOG2   = 3,
    parameter int FRAME_BITS = 32,
    parameter int SAMPLE_W   = 16,
    parameter int MSB_POS    = 30,
    parameter int GAP_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              cs,
    output logic              sck,
    input  logic [N_CH-1:0]   sdo,
    mic_spi_rx_multi_if.master bus
`ifdef MIC_SPI_PEAK_EN
    ,
    output logic [N_CH*SAMPLE_W-1:0] peak,
    input  logic                     peak_clr
`endif
);

    logic                     capture;
    logic                     frame_done;
    logic                     valid_q;
    logic                     overrun_q;
    logic [N_CH*SAMPLE_W-1:0] sample_w;

    mic_spi_sck_gen #(
        .DIV_LOG2   (DIV_LOG2),
        .FRAME_BITS (FRAME_BITS),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_sck_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .cs         (cs),
        .sck        (sck),
        .capture    (capture),
        .frame_done (frame_done)
    );

    // one data set per frame; overwrite when unconsumed, flag overrun
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= frame_done && valid_q && !bus.ready;
            if (frame_done) begin
                valid_q <= 1'b1;
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.sample  = sample_w;
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;

`ifdef MIC_SPI_PEAK_EN
    logic upd_q;

    // peaks follow the sample register by one clk
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upd_q <= 1'b0;
        end else begin
            upd_q <= frame_done;
        end
    end
`endif

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        // bits above MSB_POS never reach the sample, so not stored
        logic [MSB_POS:0]    sh;
        logic [SAMPLE_W-1:0] smp;

        // MSB-first shift on the sck rising capture edge
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sh <= '0;
            end else if (capture) begin
                sh <= {sh[MSB_POS-1:0], sdo[c]};
            end
        end

        // sample register loaded once the last bit is in
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                smp <= '0;
            end else if (frame_done) begin
                smp <= sh[MSB_POS -: SAMPLE_W];
            end
        end

        assign sample_w[c*SAMPLE_W +: SAMPLE_W] = smp;

`ifdef MIC_SPI_PEAK_EN
        logic [SAMPLE_W-1:0] pk;
        logic [SAMPLE_W-1:0] mag;

        assign mag = SAMPLE_W'(abs_mag(32'(signed'(smp))));

        // running |sample| max; clear wins but keeps a same-cycle update
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                pk <= '0;
            end else if (peak_clr) begin
                pk <= upd_q ? mag : '0;
            end else if (upd_q && (mag > pk)) begin
                pk <= mag;
            end
        end

        assign peak[c*SAMPLE_W +: SAMPLE_W] = pk;
`endif
    end

endmodule

// File: tb/tb_mic_spi_rx_multi.sv
// tb_mic_spi_rx_multi: two receiver instances (defaults and a fast
// 2-channel build) against SPI slave models and a sample reference.
module tb_mic_spi_rx_multi;

    localparam int FB    = 32;
    localparam int SW    = 16;
    localparam int MSB   = 30;
    localparam int A_DIV = 1;
    localparam int A_GAP = 8;
    localparam int A_H   = 2;
    localparam int B_H   = 8;
    localparam int A_PER = A_H + 2 * A_H * FB + A_GAP;
    localparam int B_PER = 584;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ovr_a  = 0;

    always @(posedge clk) cyc++;

    logic       rst_a_n, en_a, cs_a, sck_a;
    logic [1:0] sdo_a;
    logic       rst_b_n, en_b, cs_b, sck_b;
    logic [0:0] sdo_b;

    mic_spi_rx_multi_if #(.N_CH(2), .SAMPLE_W(SW)) bus_a ();
    mic_spi_rx_multi_if #(.N_CH(1), .SAMPLE_W(SW)) bus_b ();

`ifdef MIC_SPI_PEAK_EN
    logic [31:0] peak_a;
    logic        peak_clr_a;
    logic [15:0] peak_b;
    logic        peak_clr_b;
`endif

    mic_spi_rx_multi #(
        .N_CH(2), .DIV_LOG2(A_DIV), .FRAME_BITS(FB),
        .SAMPLE_W(SW), .MSB_POS(MSB), .GAP_CYCLES(A_GAP)
    ) dut_a (
        .clk(clk), .reset_n(rst_a_n), .enable(en_a),
        .cs(cs_a), .sck(sck_a), .sdo(sdo_a), .bus(bus_a)
`ifdef MIC_SPI_PEAK_EN
        , .peak(peak_a), .peak_clr(peak_clr_a)
`endif
    );

    mic_spi_rx_multi dut_b (
        .clk(clk), .reset_n(rst_b_n), .enable(en_b),
        .cs(cs_b), .sck(sck_b), .sdo(sdo_b), .bus(bus_b)
`ifdef MIC_SPI_PEAK_EN
        , .peak(peak_b), .peak_clr(peak_clr_b)
`endif
    );

    // reference: sample is frame bits MSB..MSB-SW+1 of the sent word
    function automatic logic [15:0] ref_sample(input logic [31:0] w);
        return 16'(w >> (MSB - SW + 1));
    endfunction

    function automatic int mag16(input logic [15:0] s);
        int v;
        v = $signed(s);
        return (v < 0) ? -v : v;
    endfunction

    logic [63:0] txq_a[$];
    logic [31:0] expq_a[$];
    logic [31:0] txq_b[$];
    logic [15:0] expq_b[$];
    logic [31:0] sh_a0, sh_a1, sh_b;

    // slave A: new word per cs fall, bit out on each sck fall
    always @(negedge cs_a) begin
        logic [63:0] w;
        if (txq_a.size() != 0) w = txq_a.pop_front();
        else w = {$urandom(), $urandom()};
        sh_a0 = w[31:0];
        sh_a1 = w[63:32];
        expq_a.push_back({ref_sample(w[63:32]), ref_sample(w[31:0])});
    end

    always @(negedge sck_a) begin
        if (cs_a === 1'b0) begin
            sdo_a = {sh_a1[31], sh_a0[31]};
            sh_a0 = sh_a0 << 1;
            sh_a1 = sh_a1 << 1;
        end
    end

    always @(negedge cs_b) begin
        logic [31:0] w;
        if (txq_b.size() != 0) w = txq_b.pop_front();
        else w = $urandom();
        sh_b = w;
        expq_b.push_back(ref_sample(w));
    end

    always @(negedge sck_b) begin
        if (cs_b === 1'b0) begin
            sdo_b = sh_b[31];
            sh_b  = sh_b << 1;
        end
    end

    always @(negedge clk) if (bus_a.overrun === 1'b1) ovr_a++;

    task automatic wait_valid_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_b.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_fall_a(output bit ok);
        bit hi;
        hi = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4 * A_PER; i++) begin
            @(negedge clk);
            if (cs_a === 1'b1) hi = 1'b1;
            else if (hi && cs_a === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
        bus_a.ready = 1'b0;
        bus_b.ready = 1'b0;
`ifdef MIC_SPI_PEAK_EN
        peak_clr_a = 1'b0;
        peak_clr_b = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_a, sck_a, bus_a.valid, bus_a.overrun} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pins_a: got %b want 1100",
                     {cs_a, sck_a, bus_a.valid, bus_a.overrun});
        end
        checks++;
        if (bus_a.sample !== 32'h0) begin
            errors++;
            $display("FAIL reset_sample_a: got %h want 0", bus_a.sample);
        end
        checks++;
        if ({cs_b, sck_b, bus_b.valid, bus_b.overrun} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pins_b: got %b want 1100",
                     {cs_b, sck_b, bus_b.valid, bus_b.overrun});
        end
        checks++;
        if (bus_b.sample !== 16'h0) begin
            errors++;
            $display("FAIL reset_sample_b: got %h want 0", bus_b.sample);
        end
`ifdef MIC_SPI_PEAK_EN
        checks++;
        if (peak_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_peak_a: got %h want 0", peak_a);
        end
`endif
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (4) @(negedge clk);
        txq_a.delete();
        expq_a.delete();
        txq_b.delete();
        expq_b.delete();
        checks++;
        if (cs_a !== 1'b1 || cs_b !== 1'b1) begin
            errors++;
            $display("FAIL idle_cs: got %b%b want 11", cs_a, cs_b);
        end
    endtask

    task automatic test_default_frame();
        bit ok;
        int n, t1, t2;
        bus_b.ready = 1'b1;
        txq_b.push_back(32'h7FFF_8000);
        en_b = 1'b1;
        @(negedge clk);
        checks++;
        if (cs_b !== 1'b0) begin
            errors++;
            $display("FAIL cs_fall_delay: cs got %b want 0", cs_b);
        end
        n = 0;
        while (sck_b === 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != B_H) begin
            errors++;
            $display("FAIL sck_first_fall: got %0d want %0d", n, B_H);
        end
        wait_valid_b(2 * B_PER, ok);
        t1 = cyc;
        checks++;
        if (!ok || expq_b.size() == 0) begin
            errors++;
            $display("FAIL frame_b0: got no valid want valid");
        end else if (bus_b.sample !== expq_b.pop_front()) begin
            errors++;
            $display("FAIL frame_b0: got %h want ffff", bus_b.sample);
        end
        @(negedge clk);
        checks++;
        if (bus_b.valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got %b want 0", bus_b.valid);
        end
        wait_valid_b(2 * B_PER, ok);
        t2 = cyc;
        checks++;
        if (!ok || (t2 - t1) != B_PER) begin
            errors++;
            $display("FAIL period_b: got %0d want %0d", t2 - t1, B_PER);
        end
        checks++;
        if (!ok || expq_b.size() == 0) begin
            errors++;
            $display("FAIL frame_b1: got no valid want valid");
        end else begin
            logic [15:0] e;
            e = expq_b.pop_front();
            if (bus_b.sample !== e) begin
                errors++;
                $display("FAIL frame_b1: got %h want %h", bus_b.sample, e);
            end
        end
        en_b = 1'b0;
    endtask

    task automatic test_multi();
        bit ok;
        int tp;
        logic [31:0] e;
        bus_a.ready = 1'b1;
        txq_a.push_back({32'h8765_4321, 32'h1234_5678});
        en_a = 1'b1;
        tp = 0;
        for (int f = 0; f < 6; f++) begin
            wait_valid_a(2 * A_PER, ok);
            checks++;
            if (!ok || expq_a.size() == 0) begin
                errors++;
                $display("FAIL multi_%0d: got no valid want valid", f);
                continue;
            end
            e = expq_a.pop_front();
            if (bus_a.sample !== e) begin
                errors++;
                $display("FAIL multi_%0d: got %h want %h",
                         f, bus_a.sample, e);
            end
            if (f == 0) begin
                checks++;
                if (bus_a.sample !== 32'h0ECA_2468) begin
                    errors++;
                    $display("FAIL multi_fixed: got %h want 0eca2468",
                             bus_a.sample);
                end
            end else begin
                checks++;
                if ((cyc - tp) != A_PER) begin
                    errors++;
                    $display("FAIL period_a_%0d: got %0d want %0d",
                             f, cyc - tp, A_PER);
                end
            end
            tp = cyc;
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int base;
        logic [31:0] e;
        @(negedge clk);
        bus_a.ready = 1'b0;
        base = ovr_a;
        wait_valid_a(2 * A_PER, ok);
        if (expq_a.size() != 0) e = expq_a.pop_front();
        ok = 1'b0;
        for (int i = 0; i < 2 * A_PER; i++) begin
            @(negedge clk);
            if (bus_a.overrun === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || expq_a.size() == 0) begin
            errors++;
            $display("FAIL overrun_seen: got none want pulse");
        end else begin
            e = expq_a.pop_front();
            if (bus_a.sample !== e || bus_a.valid !== 1'b1) begin
                errors++;
                $display("FAIL overrun_data: got %h/%b want %h/1",
                         bus_a.sample, bus_a.valid, e);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_a.overrun !== 1'b0 || (ovr_a - base) != 1) begin
            errors++;
            $display("FAIL overrun_once: got %0d pulses want 1",
                     ovr_a - base);
        end
        bus_a.ready = 1'b1;
        @(negedge clk);
        bus_a.ready = 1'b0;
        checks++;
        if (bus_a.valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_clear: got %b want 0", bus_a.valid);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] e;
        wait_valid_a(2 * A_PER, ok);
        if (expq_a.size() != 0) e = expq_a.pop_front();
        wait_cs_fall_a(ok);
        repeat (A_H + 10 * 2 * A_H) @(negedge clk);
        rst_a_n = 1'b0;
        @(negedge clk);
        expq_a.delete();
        checks++;
        if ({cs_a, sck_a, bus_a.valid} !== 3'b110 || !ok) begin
            errors++;
            $display("FAIL midreset_pins: got %b want 110",
                     {cs_a, sck_a, bus_a.valid});
        end
        checks++;
        if (bus_a.sample !== 32'h0) begin
            errors++;
            $display("FAIL midreset_sample: got %h want 0", bus_a.sample);
        end
        rst_a_n = 1'b1;
        bus_a.ready = 1'b1;
        wait_valid_a(2 * A_PER, ok);
        checks++;
        if (!ok || expq_a.size() == 0) begin
            errors++;
            $display("FAIL after_reset: got no valid want valid");
        end else begin
            e = expq_a.pop_front();
            if (bus_a.sample !== e) begin
                errors++;
                $display("FAIL after_reset: got %h want %h",
                         bus_a.sample, e);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int lows;
        logic [31:0] e;
        wait_cs_fall_a(ok);
        repeat (A_H + 5 * 2 * A_H) @(negedge clk);
        en_a = 1'b0;
        wait_valid_a(2 * A_PER, ok);
        checks++;
        if (!ok || expq_a.size() == 0) begin
            errors++;
            $display("FAIL drop_frame: got no valid want valid");
        end else begin
            e = expq_a.pop_front();
            if (bus_a.sample !== e) begin
                errors++;
                $display("FAIL drop_frame: got %h want %h",
                         bus_a.sample, e);
            end
        end
        lows = 0;
        repeat (2 * A_PER) begin
            @(negedge clk);
            if (cs_a !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL drop_idle: got %0d cs-low cycles want 0", lows);
        end
    endtask

`ifdef MIC_SPI_PEAK_EN
    task automatic test_peak();
        bit ok;
        int pk0, pk1;
        logic [15:0] s0v [4];
        logic [31:0] e, w0;
        s0v[0] = 16'h0100;
        s0v[1] = 16'h8000;
        s0v[2] = 16'h0005;
        s0v[3] = 16'h0003;
        peak_clr_a = 1'b1;
        @(negedge clk);
        peak_clr_a = 1'b0;
        @(negedge clk);
        checks++;
        if (peak_a !== 32'h0) begin
            errors++;
            $display("FAIL peak_clear: got %h want 0", peak_a);
        end
        for (int f = 0; f < 4; f++) begin
            w0 = ($urandom() & 32'h8000_7FFF) | ({16'h0, s0v[f]} << 15);
            txq_a.push_back({$urandom(), w0});
        end
        pk0 = 0;
        pk1 = 0;
        en_a = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_valid_a(2 * A_PER, ok);
            if (!ok || expq_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL peak_frame_%0d: got no valid want valid", f);
                continue;
            end
            e = expq_a.pop_front();
            if (f == 3) begin
                peak_clr_a = 1'b1;
                en_a = 1'b0;
                pk0 = mag16(e[15:0]);
                pk1 = mag16(e[31:16]);
            end else begin
                if (mag16(e[15:0]) > pk0) pk0 = mag16(e[15:0]);
                if (mag16(e[31:16]) > pk1) pk1 = mag16(e[31:16]);
            end
            @(negedge clk);
            peak_clr_a = 1'b0;
            checks++;
            if (peak_a !== {16'(pk1), 16'(pk0)}) begin
                errors++;
                $display("FAIL peak_%0d: got %h want %h",
                         f, peak_a, {16'(pk1), 16'(pk0)});
            end
        end
    endtask
`endif

    initial begin
        sdo_a = 2'b00;
        sdo_b = 1'b0;
        test_reset();
        test_default_frame();
        test_multi();
        test_overrun();
        test_reset_mid();
        test_enable_drop();
`ifdef MIC_SPI_PEAK_EN
        test_peak();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
